// File: rtl/hilo_muldiv_ctrl.sv
// HI/LO multiply/divide sequencer for a MIPS-style EX stage.
// One radix-2 step per cycle: shift-add multiply or restoring divide on
// operand magnitudes, with sign correction applied when the result is
// registered on entry to DONE. The pipeline is stalled while CALC runs.
module hilo_muldiv_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        flush,
  output logic        stall,
  output logic        hilo_pending,
  output logic        hilo_we,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Two's-complement negate of a 32-bit value.
  function automatic logic [31:0] neg32(input logic [31:0] v);
    return ~v + 32'd1;
  endfunction

  // Magnitude of a value, treated as signed only when is_signed is set.
  function automatic logic [31:0] mag32(input logic [31:0] v, input logic is_signed);
    return (is_signed && v[31]) ? neg32(v) : v;
  endfunction

  logic [1:0]  state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [1:0]  op_q, op_d;
  logic [31:0] acc_hi_q, acc_hi_d;   // product upper half / partial remainder
  logic [31:0] acc_lo_q, acc_lo_d;   // multiplier shifting out / quotient shifting in
  logic [31:0] opnd_q, opnd_d;       // multiplicand or divisor magnitude
  logic [31:0] dvd_raw_q, dvd_raw_d; // raw dividend for the divide-by-zero result
  logic        neg_lo_q, neg_lo_d;   // product / quotient needs negation
  logic        neg_hi_q, neg_hi_d;   // remainder needs negation
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  logic        accept_s;
  logic        is_signed_s;
  logic [31:0] a_mag_s, b_mag_s;
  logic [32:0] sum_s;
  logic [32:0] rem_sh_s, diff_s;
  logic [31:0] step_hi_s, step_lo_s;
  logic [63:0] prod_s;

  assign accept_s = rst_n & (state_q == ST_IDLE) & start & ~flush;

  // One datapath step plus next-state and result selection.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    acc_hi_d  = acc_hi_q;
    acc_lo_d  = acc_lo_q;
    opnd_d    = opnd_q;
    dvd_raw_d = dvd_raw_q;
    neg_lo_d  = neg_lo_q;
    neg_hi_d  = neg_hi_q;
    hi_d      = hi_q;
    lo_d      = lo_q;

    is_signed_s = ~op[0];
    a_mag_s     = mag32(src_a, is_signed_s);
    b_mag_s     = mag32(src_b, is_signed_s);

    // Shift-add multiply step: add multiplicand if multiplier LSB set, shift right.
    sum_s = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : 33'd0);

    // Restoring divide step: shift remainder left, trial-subtract divisor.
    rem_sh_s = {acc_hi_q, acc_lo_q[31]};
    diff_s   = rem_sh_s - {1'b0, opnd_q};

    if (op_q[1]) begin
      if (!diff_s[32]) begin
        step_hi_s = diff_s[31:0];
        step_lo_s = {acc_lo_q[30:0], 1'b1};
      end else begin
        step_hi_s = rem_sh_s[31:0];
        step_lo_s = {acc_lo_q[30:0], 1'b0};
      end
    end else begin
      step_hi_s = sum_s[32:1];
      step_lo_s = {sum_s[0], acc_lo_q[31:1]};
    end

    prod_s = {step_hi_s, step_lo_s};

    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          state_d   = ST_CALC;
          cnt_d     = 5'd0;
          op_d      = op;
          acc_hi_d  = 32'd0;
          acc_lo_d  = op[1] ? a_mag_s : b_mag_s;
          opnd_d    = op[1] ? b_mag_s : a_mag_s;
          dvd_raw_d = src_a;
          neg_lo_d  = is_signed_s & (src_a[31] ^ src_b[31]);
          neg_hi_d  = is_signed_s & src_a[31];
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CALC: begin
        if (flush) begin
          state_d = ST_IDLE;
        end else begin
          acc_hi_d = step_hi_s;
          acc_lo_d = step_lo_s;
          cnt_d    = cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            state_d = ST_DONE;
            if (op_q[1] && (opnd_q == 32'd0)) begin
              // Divide by zero: fixed quotient, dividend passed through unsigned.
              hi_d = dvd_raw_q;
              lo_d = 32'hFFFF_FFFF;
            end else if (op_q[1]) begin
              hi_d = neg_hi_q ? neg32(step_hi_s) : step_hi_s;
              lo_d = neg_lo_q ? neg32(step_lo_s) : step_lo_s;
            end else if (neg_lo_q) begin
              {hi_d, lo_d} = ~prod_s + 64'd1;
            end else begin
              {hi_d, lo_d} = prod_s;
            end
          end else begin
            state_d = ST_CALC;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 5'd0;
      op_q      <= 2'd0;
      acc_hi_q  <= 32'd0;
      acc_lo_q  <= 32'd0;
      opnd_q    <= 32'd0;
      dvd_raw_q <= 32'd0;
      neg_lo_q  <= 1'b0;
      neg_hi_q  <= 1'b0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      acc_hi_q  <= acc_hi_d;
      acc_lo_q  <= acc_lo_d;
      opnd_q    <= opnd_d;
      dvd_raw_q <= dvd_raw_d;
      neg_lo_q  <= neg_lo_d;
      neg_hi_q  <= neg_hi_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign stall        = accept_s | (state_q == ST_CALC);
  assign hilo_pending = accept_s | (state_q == ST_CALC) | (state_q == ST_DONE);
  assign hilo_we      = (state_q == ST_DONE);
  assign hi_out       = hi_q;
  assign lo_out       = lo_q;

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Randomized self-checking bench for hilo_muldiv_ctrl against an
// arithmetic reference model and cycle-count timing expectations.
module tb_hilo_muldiv_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'd0;
  logic [31:0] src_a = 32'd0;
  logic [31:0] src_b = 32'd0;
  logic        flush = 1'b0;
  logic        stall, hilo_pending, hilo_we;
  logic [31:0] hi_out, lo_out;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] exp_hi = 32'd0;
  logic [31:0] exp_lo = 32'd0;

  hilo_muldiv_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op),
    .src_a(src_a), .src_b(src_b), .flush(flush),
    .stall(stall), .hilo_pending(hilo_pending), .hilo_we(hilo_we),
    .hi_out(hi_out), .lo_out(lo_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Reference result {HI, LO} from plain arithmetic.
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb, q, r;
    logic [63:0] ua, ub;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (o)
      2'b00: return sa * sb;
      2'b01: return ua * ub;
      2'b10: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      default: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        q = ua / ub;
        r = ua % ub;
        return {r[31:0], q[31:0]};
      end
    endcase
  endfunction

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  // Cycle 0 presents the op; cycles 1..32 stall with scrambled operands; cycle 33 writes.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input bit flush_done, input bit chain);
    logic [63:0] r;
    r = model(o, a, b);
    for (int c = 0; c <= 33; c++) begin
      if (c == 0) begin
        start = 1'b1; op = o; src_a = a; src_b = b; flush = 1'b0;
      end else if (c <= 32) begin
        start = 1'b1; src_a = $urandom; src_b = $urandom;
      end else begin
        flush = flush_done;
        start = chain;
        if (chain) begin
          op = 2'($urandom_range(0, 3)); src_a = $urandom; src_b = $urandom;
        end
      end
      #4;
      check("stall", stall, c <= 32);
      check("hilo_we", hilo_we, c == 33);
      check("pending", hilo_pending, 1'b1);
      if (c == 33) begin
        exp_hi = r[63:32];
        exp_lo = r[31:0];
      end
      if (c == 0 || c >= 32) begin
        check("hi_out", hi_out, exp_hi);
        check("lo_out", lo_out, exp_lo);
      end
      next_cycle();
    end
    start = 1'b0;
    flush = 1'b0;
  endtask

  initial begin
    // Reset with start asserted: every output must be zero.
    #1 rst_n = 1'b0;
    start = 1'b1;
    #2;
    check("rst_stall", stall, 1'b0);
    check("rst_pending", hilo_pending, 1'b0);
    check("rst_we", hilo_we, 1'b0);
    check("rst_hi", hi_out, 32'd0);
    check("rst_lo", lo_out, 32'd0);
    next_cycle();
    rst_n = 1'b1;
    start = 1'b0;
    next_cycle();

    // Directed corner vectors.
    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
    check("multu_hi", hi_out, 32'hFFFF_FFFE);
    check("multu_lo", lo_out, 32'h0000_0001);
    run_op(2'b00, 32'hFFFF_FFFD, 32'd5, 1'b0, 1'b0);
    check("mult_hi", hi_out, 32'hFFFF_FFFF);
    check("mult_lo", lo_out, 32'hFFFF_FFF1);
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
    check("div_hi", hi_out, 32'hFFFF_FFFF);
    check("div_lo", lo_out, 32'hFFFF_FFFD);
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
    check("divmin_hi", hi_out, 32'd0);
    check("divmin_lo", lo_out, 32'h8000_0000);
    run_op(2'b11, 32'd5, 32'd0, 1'b0, 1'b0);
    check("divu0_hi", hi_out, 32'h0000_0005);
    check("divu0_lo", lo_out, 32'hFFFF_FFFF);
    run_op(2'b10, 32'hFFFF_FFF7, 32'd0, 1'b0, 1'b0);
    check("div0_hi", hi_out, 32'hFFFF_FFF7);
    check("div0_lo", lo_out, 32'hFFFF_FFFF);

    // Randomized operations, some chained back-to-back or flushed in DONE.
    for (int i = 0; i < 24; i++) begin
      logic [1:0]  o;
      logic [31:0] a, b;
      o = 2'($urandom_range(0, 3));
      a = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
      b = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 3) == 0) b = b >> $urandom_range(1, 31);
      run_op(o, a, b, (i % 4) == 1, (i % 3) == 0);
    end

    // start with flush in IDLE must not be accepted.
    for (int c = 0; c < 3; c++) begin
      start = 1'b1; flush = 1'b1;
      #4;
      check("idleflush_stall", stall, 1'b0);
      check("idleflush_pending", hilo_pending, 1'b0);
      next_cycle();
    end
    start = 1'b0; flush = 1'b0;
    next_cycle();

    // Flush at CALC cycle 10: no write, outputs unchanged.
    for (int c = 0; c <= 10; c++) begin
      start = (c < 10);
      if (c == 0) begin
        op = 2'b01; src_a = $urandom; src_b = $urandom;
      end
      flush = (c == 10);
      #4;
      check("fl_stall", stall, 1'b1);
      check("fl_we", hilo_we, 1'b0);
      next_cycle();
    end
    flush = 1'b0; start = 1'b0;
    for (int c = 0; c < 40; c++) begin
      #4;
      check("postfl_stall", stall, 1'b0);
      check("postfl_we", hilo_we, 1'b0);
      check("postfl_hi", hi_out, exp_hi);
      check("postfl_lo", lo_out, exp_lo);
      next_cycle();
    end
    run_op(2'b00, $urandom, $urandom, 1'b0, 1'b0);

    // Reset at CALC cycle 20: outputs clear immediately, then a fresh op.
    for (int c = 0; c < 20; c++) begin
      start = 1'b1;
      if (c == 0) begin
        op = 2'b11; src_a = $urandom; src_b = $urandom_range(1, 1000);
      end
      next_cycle();
    end
    rst_n = 1'b0;
    #1;
    exp_hi = 32'd0;
    exp_lo = 32'd0;
    check("mrst_stall", stall, 1'b0);
    check("mrst_pending", hilo_pending, 1'b0);
    check("mrst_we", hilo_we, 1'b0);
    check("mrst_hi", hi_out, 32'd0);
    check("mrst_lo", lo_out, 32'd0);
    next_cycle();
    rst_n = 1'b1;
    run_op(2'b10, $urandom, $urandom_range(1, 5000), 1'b0, 1'b1);
    run_op(2'b01, $urandom, $urandom, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
